uart_rx_unit: RTL

UART_RX_UNIT -- requirements
Module: uart_rx_unit

---
 rtl/uart_rx_unit.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_unit.sv
// UART receiver: 16x oversampled, LSB first, one word per rx_done_tick.
// Define UART_RX_PARITY_EN to receive and check a parity bit after the data bits.
module uart_rx_unit #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            frame_err,
  output logic            parity_err
);

  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  if (DBIT < 5 || DBIT > 8 || SB_TICK < 16 || SB_TICK > 32 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_cfg_bad
    $error("uart_rx_unit: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;
  logic            rx_q;
  logic            rx_s;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      rx_q <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_q <= rx;
      rx_s <= rx_q;
    end
  end

`ifdef UART_RX_PARITY_EN
  localparam logic ODD = 1'(PARITY_ODD);
  logic par;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      par        <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      if (state == PARITY && s_tick && s == S_BIT)
        par <= rx_s;
      if (state == STOP && s_tick && s == S_STOP)
        parity_err <= ((^b) ^ par) != ODD;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

  // dout/frame_err load on the STOP exit edge, so the pulse
  // cycle already shows the new word
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      b            <= '0;
      dout         <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      rx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == S_MID) begin
              s     <= '0;
              n     <= '0;
              state <= rx_s ? IDLE : DATA;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rx_s, b[DBIT-1:1]};
              n <= n + 1'b1;
              if (n == N_LAST)
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (s_tick) begin
            if (s == S_BIT) begin
              s     <= '0;
              state <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (s_tick) begin
            if (s == S_STOP) begin
              s            <= '0;
              state        <= IDLE;
              rx_done_tick <= 1'b1;
              dout         <= b;
              frame_err    <= ~rx_s;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
